// File: rtl/bnn_stream_loader.sv
// Serial loader filling the BNN image bitmap and kernel bank
// from two independent qualified 1-bit streams.
module bnn_stream_loader #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 3,
   parameter int NUM_K = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic                     d_in_p,
   input  logic                     valid_p,
   input  logic                     d_in_w,
   input  logic                     valid_w,
   output logic [IMG_H*IMG_W-1:0]   pixels,
   output logic [NUM_K*K*K-1:0]     weights,
   output logic                     busy,
   output logic                     pic_done,
   output logic                     w_done,
   output logic                     load_done,
   output logic                     done_pulse
);

   localparam int NPIX = IMG_H * IMG_W;
   localparam int NWT  = NUM_K * K * K;
   localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int WW   = (NWT > 1) ? $clog2(NWT) : 1;
   localparam logic [PW-1:0] PLAST = PW'(NPIX - 1);
   localparam logic [WW-1:0] WLAST = WW'(NWT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic            r_dp;
   logic            r_vp;
   logic            r_dw;
   logic            r_vw;
   logic            r_sel_p;
   logic            r_sel_w;
   logic [PW-1:0]   r_pcnt;
   logic [WW-1:0]   r_wcnt;
   logic [NPIX-1:0] r_pixels;
   logic [NWT-1:0]  r_weights;
   logic            r_pic_done;
   logic            r_w_done;
   logic            r_busy;
   logic            r_done_pulse;

   logic w_arm;
   logic w_mp_sel;
   logic w_mw_sel;
   logic w_p_wr;
   logic w_w_wr;
   logic w_p_fin;
   logic w_w_fin;

   // mode 11 falls through to "both"
   assign w_mp_sel = (mode != 2'b10);
   assign w_mw_sel = (mode != 2'b01);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_p_wr      = 1'b0;
      w_w_wr      = 1'b0;
      w_p_fin     = 1'b0;
      w_w_fin     = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_LOAD;
               w_arm       = 1'b1;
            end
         end
         S_LOAD: begin
            w_p_wr  = r_sel_p && !r_pic_done && r_vp;
            w_w_wr  = r_sel_w && !r_w_done && r_vw;
            w_p_fin = w_p_wr && (r_pcnt == PLAST);
            w_w_fin = w_w_wr && (r_wcnt == WLAST);
            if ((!r_sel_p || r_pic_done || w_p_fin) &&
                (!r_sel_w || r_w_done || w_w_fin)) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dp         <= 1'b0;
         r_vp         <= 1'b0;
         r_dw         <= 1'b0;
         r_vw         <= 1'b0;
         r_sel_p      <= 1'b0;
         r_sel_w      <= 1'b0;
         r_pcnt       <= '0;
         r_wcnt       <= '0;
         r_pixels     <= '0;
         r_weights    <= '0;
         r_pic_done   <= 1'b0;
         r_w_done     <= 1'b0;
         r_busy       <= 1'b0;
         r_done_pulse <= 1'b0;
      end else begin
         r_dp         <= d_in_p;
         r_vp         <= valid_p;
         r_dw         <= d_in_w;
         r_vw         <= valid_w;
         r_busy       <= (w_state_nxt == S_LOAD);
         r_done_pulse <= (r_state == S_LOAD) &&
                         (w_state_nxt == S_DONE);
         // arrays are not cleared on arm; they are overwritten in order
         if (w_arm) begin
            r_sel_p <= w_mp_sel;
            r_sel_w <= w_mw_sel;
            if (w_mp_sel) begin
               r_pcnt     <= '0;
               r_pic_done <= 1'b0;
            end
            if (w_mw_sel) begin
               r_wcnt   <= '0;
               r_w_done <= 1'b0;
            end
         end
         if (w_p_wr) begin
            r_pixels[r_pcnt] <= r_dp;
            if (w_p_fin) begin
               r_pcnt     <= '0;
               r_pic_done <= 1'b1;
            end else begin
               r_pcnt <= r_pcnt + 1'b1;
            end
         end
         if (w_w_wr) begin
            r_weights[r_wcnt] <= r_dw;
            if (w_w_fin) begin
               r_wcnt   <= '0;
               r_w_done <= 1'b1;
            end else begin
               r_wcnt <= r_wcnt + 1'b1;
            end
         end
      end
   end

   assign pixels     = r_pixels;
   assign weights    = r_weights;
   assign busy       = r_busy;
   assign pic_done   = r_pic_done;
   assign w_done     = r_w_done;
   assign done_pulse = r_done_pulse;
   assign load_done  = r_pic_done & r_w_done;

endmodule

// File: tb/tb_bnn_stream_loader.sv
// Bench for bnn_stream_loader: default-size and small-size instances
// checked against an in-order stream model.
module tb_bnn_stream_loader;

   localparam int NPA = 784;
   localparam int NWA = 72;
   localparam int NPB = 16;
   localparam int NWB = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic           start_a = 0, dpa = 0, vpa = 0, dwa = 0, vwa = 0;
   logic [1:0]     mode_a = 0;
   logic [NPA-1:0] pix_a;
   logic [NWA-1:0] wt_a;
   logic           busy_a, pd_a, wd_a, ld_a, dp_a;

   logic           start_b = 0, dpb = 0, vpb = 0, dwb = 0, vwb = 0;
   logic [1:0]     mode_b = 0;
   logic [NPB-1:0] pix_b;
   logic [NWB-1:0] wt_b;
   logic           busy_b, pd_b, wd_b, ld_b, dp_b;

   bnn_stream_loader u_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .mode(mode_a),
      .d_in_p(dpa), .valid_p(vpa), .d_in_w(dwa), .valid_w(vwa),
      .pixels(pix_a), .weights(wt_a), .busy(busy_a),
      .pic_done(pd_a), .w_done(wd_a), .load_done(ld_a),
      .done_pulse(dp_a));

   bnn_stream_loader #(.IMG_W(4), .IMG_H(4), .K(2), .NUM_K(2)) u_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode_b),
      .d_in_p(dpb), .valid_p(vpb), .d_in_w(dwb), .valid_w(vwb),
      .pixels(pix_b), .weights(wt_b), .busy(busy_b),
      .pic_done(pd_b), .w_done(wd_b), .load_done(ld_b),
      .done_pulse(dp_b));

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int pd_rise = -1, wd_rise = -1, dp_rise = -1, busy_fall = -1;
   int dp_cnt = 0;
   int lastp = -1, lastw = -1;
   logic pd_q = 0, wd_q = 0, busy_q = 0;

   bit qp[$];
   bit qw[$];
   logic [NPA-1:0] exp_pix = '0;
   logic [NWA-1:0] exp_w = '0;
   logic exp_pd = 0, exp_wd = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (pd_a && !pd_q) pd_rise = cyc;
      if (wd_a && !wd_q) wd_rise = cyc;
      if (!busy_a && busy_q) busy_fall = cyc;
      if (dp_a) begin
         dp_cnt++;
         dp_rise = cyc;
      end
      pd_q = pd_a;
      wd_q = wd_a;
      busy_q = busy_a;
   end

   task automatic chk(input string tag, input logic [1023:0] obs,
                      input logic [1023:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Selected section takes the first N valid bits in order; rest ignored.
   task automatic model(input bit sp, input bit sw);
      if (sp) begin
         for (int i = 0; i < qp.size() && i < NPA; i++) exp_pix[i] = qp[i];
         exp_pd = (qp.size() >= NPA);
      end
      if (sw) begin
         for (int i = 0; i < qw.size() && i < NWA; i++) exp_w[i] = qw[i];
         exp_wd = (qw.size() >= NWA);
      end
   endtask

   task automatic clr_mon();
      pd_rise = -1; wd_rise = -1; dp_rise = -1; busy_fall = -1;
      dp_cnt = 0; lastp = -1; lastw = -1;
   endtask

   task automatic stream_a(input bit gaps, input int inj);
      int ip = 0;
      int iw = 0;
      bit fired = 0;
      for (int c = 0; c < 5000 && (ip < qp.size() || iw < qw.size()); c++) begin
         @(negedge clk);
         start_a = 0;
         if (inj >= 0 && !fired && iw == inj) begin
            start_a = 1;
            mode_a = 2'b01;
            fired = 1;
         end
         if (ip < qp.size() && (!gaps || $urandom_range(1, 0) == 1)) begin
            dpa = qp[ip];
            vpa = 1;
            ip++;
            if (ip == qp.size()) lastp = cyc;
         end else begin
            vpa = 0;
            dpa = 1'($urandom);
         end
         if (iw < qw.size() && (!gaps || $urandom_range(1, 0) == 1)) begin
            dwa = qw[iw];
            vwa = 1;
            iw++;
            if (iw == qw.size()) lastw = cyc;
         end else begin
            vwa = 0;
            dwa = 1'($urandom);
         end
      end
      @(negedge clk);
      vpa = 0;
      vwa = 0;
      start_a = 0;
      chk("stream_budget", ip + iw, qp.size() + qw.size());
   endtask

   task automatic wait_idle_a();
      for (int c = 0; c < 50 && busy_a; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("a_idle", busy_a, 0);
   endtask

   task automatic start_a_task(input logic [1:0] m);
      @(negedge clk);
      start_a = 1;
      mode_a = m;
      @(negedge clk);
      start_a = 0;
      mode_a = 2'($urandom);
      chk("a_busy_on_start", busy_a, 1);
   endtask

   task automatic chk_a_state(input string tag);
      chk({tag, "_pix"}, pix_a, exp_pix);
      chk({tag, "_wt"}, wt_a, exp_w);
      chk({tag, "_pd"}, pd_a, exp_pd);
      chk({tag, "_wd"}, wd_a, exp_wd);
      chk({tag, "_ld"}, ld_a, exp_pd & exp_wd);
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, "_pix"}, pix_a, 0);
      chk({tag, "_wt"}, wt_a, 0);
      chk({tag, "_busy"}, busy_a, 0);
      chk({tag, "_pd"}, pd_a, 0);
      chk({tag, "_wd"}, wd_a, 0);
      chk({tag, "_ld"}, ld_a, 0);
      chk({tag, "_dp"}, dp_a, 0);
   endtask

   logic [15:0] pat = 16'hA5C3;
   logic [NWB-1:0] exp_wb = '0;

   initial begin
      // reset
      repeat (3) @(negedge clk);
      chk_a_zero("rst");
      chk("rst_b_pix", pix_b, 0);
      chk("rst_b_busy", busy_b, 0);
      @(negedge clk);
      reset_n = 1;

      // no start: valid bits must be ignored
      clr_mon();
      qp.delete(); qw.delete();
      for (int i = 0; i < NPA; i++) qp.push_back(1);
      for (int i = 0; i < NWA; i++) qw.push_back(1);
      stream_a(0, -1);
      repeat (2) @(negedge clk);
      chk_a_zero("nostart");
      chk("nostart_dpcnt", dp_cnt, 0);

      // full load, mode 00, pixel i = i%2, weights all ones
      clr_mon();
      qp.delete(); qw.delete();
      for (int i = 0; i < NPA; i++) qp.push_back(bit'(i % 2));
      for (int i = 0; i < NWA; i++) qw.push_back(1);
      start_a_task(2'b00);
      stream_a(0, -1);
      wait_idle_a();
      model(1, 1);
      chk_a_state("full");
      chk("full_wd_rise", wd_rise, lastw + 2);
      chk("full_pd_rise", pd_rise, lastp + 2);
      chk("full_dp_rise", dp_rise, lastp + 2);
      chk("full_dp_cnt", dp_cnt, 1);
      chk("full_busy_fall", busy_fall, dp_rise);

      // weights-only reload with zeros; pixel stream must be ignored
      clr_mon();
      qp.delete(); qw.delete();
      for (int i = 0; i < 100; i++) qp.push_back(1'($urandom));
      for (int i = 0; i < NWA; i++) qw.push_back(0);
      start_a_task(2'b10);
      chk("wo_pd_hold", pd_a, 1);
      stream_a(0, -1);
      wait_idle_a();
      model(0, 1);
      chk_a_state("wo");
      chk("wo_dp_rise", dp_rise, lastw + 2);
      chk("wo_dp_cnt", dp_cnt, 1);

      // gaps and overflow on the small instance
      @(negedge clk);
      start_b = 1;
      mode_b = 2'b00;
      @(negedge clk);
      start_b = 0;
      for (int i = 0; i < 42; i++) begin
         vpb = ((i % 2) == 0);
         dpb = (i / 2 < 16) ? pat[i / 2] : 1'b1;
         @(negedge clk);
      end
      vpb = 0;
      repeat (2) @(negedge clk);
      chk("b_pix_gap", pix_b, 16'hA5C3);
      chk("b_pd", pd_b, 1);
      chk("b_busy_wait", busy_b, 1);
      for (int i = 0; i < NWB; i++) begin
         exp_wb[i] = 1'($urandom);
         dwb = exp_wb[i];
         vwb = 1;
         @(negedge clk);
      end
      vwb = 0;
      repeat (3) @(negedge clk);
      chk("b_pix_final", pix_b, 16'hA5C3);
      chk("b_wt", wt_b, exp_wb);
      chk("b_ld", ld_b, 1);
      chk("b_busy_end", busy_b, 0);

      // reset in the middle of a load
      clr_mon();
      qp.delete(); qw.delete();
      for (int i = 0; i < 400; i++) qp.push_back(1'($urandom));
      for (int i = 0; i < 30; i++) qw.push_back(1'($urandom));
      start_a_task(2'b00);
      stream_a(0, -1);
      @(negedge clk);
      reset_n = 0;
      #1;
      chk_a_zero("midrst");
      chk("midrst_b_pix", pix_b, 0);
      @(negedge clk);
      reset_n = 1;
      exp_pix = '0; exp_w = '0; exp_pd = 0; exp_wd = 0;
      @(negedge clk);
      chk("midrst_idle", busy_a, 0);

      // fresh randomized load with gaps, mode 11 behaves as 00
      clr_mon();
      qp.delete(); qw.delete();
      for (int i = 0; i < NPA; i++) qp.push_back(1'($urandom));
      for (int i = 0; i < NWA; i++) qw.push_back(1'($urandom));
      start_a_task(2'b11);
      stream_a(1, -1);
      wait_idle_a();
      model(1, 1);
      chk_a_state("rnd");
      chk("rnd_dp_cnt", dp_cnt, 1);

      // second start during LOAD with 30 weights remaining
      clr_mon();
      qp.delete(); qw.delete();
      for (int i = 0; i < NPA; i++) qp.push_back(1'($urandom));
      for (int i = 0; i < NWA; i++) qw.push_back(1'($urandom));
      start_a_task(2'b00);
      stream_a(0, NWA - 30);
      wait_idle_a();
      model(1, 1);
      chk_a_state("restart");
      chk("restart_dp_cnt", dp_cnt, 1);
      chk("restart_dp_rise", dp_rise, lastp + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_stream_loader.md
Name: bnn_stream_loader

Overview:
- Parametrised serial loader that fills the BNN input image bitmap and the binary convolution kernel bank from two independent 1-bit streams.
- Sits between the off-chip pin interface and the convolution engine.
- Adds these features: configurable image, kernel and filter dimensions; per-stream valid qualifiers; a start/busy/done handshake; selective reload modes (image only, weights only, or both); and re-arming without a reset.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 3, kernel side length (K x K kernel)
- NUM_K, 8, number of kernels (filters)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that arms a load; sampled only in IDLE or DONE
- mode  input  2  load selection, captured on start: 00 both, 01 pixels only, 10 weights only, 11 treated as 00
- d_in_p  input  1  pixel data bit, synchronous to clk
- valid_p  input  1  qualifies d_in_p
- d_in_w  input  1  weight data bit, synchronous to clk
- valid_w  input  1  qualifies d_in_w
- pixels  output  IMG_H*IMG_W  image bitmap; bit index = row*IMG_W + col
- weights  output  NUM_K*K*K  kernel bank; bit index = kern*K*K + row*K + col
- busy  output  1  high while in LOAD
- pic_done  output  1  image section complete
- w_done  output  1  weight section complete
- load_done  output  1  pic_done AND w_done
- done_pulse  output  1  one-cycle pulse on the LOAD->DONE transition

Behaviour:
- Reset (asynchronous, any time, including mid-load):
  - State = IDLE.
  - pixels, weights, both counters, pic_done, w_done, busy, done_pulse and the input pipe registers all clear to 0.
  - load_done therefore reads 0.
- Input pipe: d_in_p/valid_p and d_in_w/valid_w are each registered once. A bit presented at edge t is written to the array at edge t+1.
- State machine has three states: IDLE, LOAD, DONE.
  - IDLE/DONE + start: capture mode and go to LOAD. For each selected section, clear its counter and its done flag. Array contents are not cleared; they are overwritten as bits arrive. Unselected sections keep their contents and done flag.
  - LOAD, pixel write: when the registered valid_p is high, the pixel section is selected and pic_done=0, then pixels[pcnt] <= bit and pcnt increments. On pcnt == IMG_H*IMG_W-1, pic_done <= 1 and pcnt <= 0.
  - LOAD, weight write: same rule applied to weights, wcnt and w_done, with terminal count NUM_K*K*K-1.
  - The two streams are fully independent. Both may write in the same cycle, and either may finish first.
  - LOAD -> DONE: on the edge where the last outstanding selected section completes. busy <= 0 and done_pulse <= 1 for exactly one cycle.
  - DONE: hold all outputs until the next start or reset.
- Ignore conditions:
  - start while in LOAD is ignored.
  - valid bits outside LOAD are ignored.
  - Bits arriving on a stream whose section is already done, or not selected, are ignored; no wrap-around overwrite occurs.
- Counter widths: clog2(IMG_H*IMG_W) and clog2(NUM_K*K*K), each with a minimum of 1. Counters never exceed terminal count.
- Gaps: valid may deassert for any number of cycles mid-stream; the counters hold during gaps.
- Outputs are registered, except load_done, which is combinational from the two flags.

Test Plan:
- Reset value: default parameters, assert reset_n=0 -> all outputs 0. Release reset, no start -> 784+72 valid bits of 1 cause no writes; state stays IDLE.
- Full load, default parameters: start with mode=00. Stream 784 pixels (pixel i = i%2) with valid_p continuous, and 72 weights of all 1 -> pixels = alternating 0/1 from bit 0, weights = all ones. w_done rises one cycle after the 72nd weight is presented; pic_done and done_pulse rise one cycle after the 784th pixel is presented; done_pulse lasts 1 cycle; busy drops together with done_pulse; load_done = 1.
- Weights-only reload after a full load: start with mode=10 and stream 72 zeros -> weights = 0, pixels unchanged, pic_done stays 1, done_pulse fires after the 72nd bit.
- Gaps and overflow: IMG_W=4, IMG_H=4, K=2, NUM_K=2. Pixels sent with valid_p toggling every cycle, 16 bits of 0xA5C3 LSB first, followed by 5 extra bits of 1 -> pixels = 16'hA5C3, extras ignored, pcnt = 0.
- Reset mid-operation: after 400 pixels, pulse reset_n low -> all outputs 0, state IDLE. A fresh start with a full load then completes normally.
- Start during LOAD: issue a second start with mode=01 while 30 weights remain -> ignored. The original mode=00 load completes and produces exactly one done_pulse.
